// File: rtl/mso_pkg.sv
// Shared definitions for the MSO acquisition decimator.
// Mode encodings and the avg_log2 clamp helper.
package mso_pkg;

  localparam int AVG_LOG2_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'd0,
    MODE_PEAK   = 2'd1,
    MODE_AVG    = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  function automatic logic [AVG_LOG2_WIDTH-1:0] clamp_log2(
    input logic [AVG_LOG2_WIDTH-1:0] v,
    input int unsigned               max_v
  );
    logic [31:0] v32;
    logic [31:0] m32;
    v32 = {{(32-AVG_LOG2_WIDTH){1'b0}}, v};
    m32 = max_v;
    return (v32 > m32) ? m32[AVG_LOG2_WIDTH-1:0] : v;
  endfunction

endpackage

// File: rtl/mso_decim_counter.sv
// Period counter: derives P from the active config and flags the
// first and completing sample of each decimation period.
module mso_decim_counter
  import mso_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  input  mode_e                     mode,
  input  logic [CW-1:0]             ratio,
  input  logic [AVG_LOG2_WIDTH-1:0] avg_log2,
  output logic                      first,
  output logic                      complete,
  output logic                      busy
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_eff;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] period_m1;

  always_comb begin
    period_m1 = ratio;
    if (mode == MODE_AVG)
      period_m1 = (CW'(1) << avg_log2) - CW'(1);
  end

  // A clear acts in the same cycle so a coincident sample starts afresh.
  assign cnt_eff  = clear ? '0 : cnt_q;
  assign first    = (cnt_eff == '0);
  assign complete = advance && (cnt_eff == period_m1);

  always_comb begin
    cnt_d = cnt_eff;
    if (complete)
      cnt_d = '0;
    else if (advance)
      cnt_d = cnt_eff + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/mso_decimator.sv
// Acquisition decimator after the FIR stage: sample, peak-detect
// or box-average one record per decimation period.
module mso_decimator
  import mso_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RATIO_WIDTH  = 16,
  parameter int MAX_AVG_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      cfg_update,
  input  logic [1:0]                mode,
  input  logic [RATIO_WIDTH-1:0]    decim_ratio,
  input  logic [AVG_LOG2_WIDTH-1:0] avg_log2,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [DATA_WIDTH-1:0]     out_min,
  output logic [DATA_WIDTH-1:0]     out_max,
  output logic                      busy
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH + MAX_AVG_LOG2;

  mode_e                     mode_q;
  logic [RATIO_WIDTH-1:0]    ratio_q;
  logic [AVG_LOG2_WIDTH-1:0] al_q;

  mode_e                     mode_eff;
  logic [RATIO_WIDTH-1:0]    ratio_eff;
  logic [AVG_LOG2_WIDTH-1:0] al_eff;

  logic clear;
  logic advance;
  logic first;
  logic complete;

  logic signed [DW-1:0] din;
  logic signed [AW-1:0] din_ext;
  logic signed [DW-1:0] samp_q, samp_d;
  logic signed [DW-1:0] min_q, min_d;
  logic signed [DW-1:0] max_q, max_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] avg_res;

  assign clear   = cfg_update | ~enable;
  assign advance = enable & in_valid;

  // The updating cycle already runs under the incoming config.
  assign mode_eff  = cfg_update ? mode_e'(mode) : mode_q;
  assign ratio_eff = cfg_update ? decim_ratio : ratio_q;
  assign al_eff    = cfg_update ? clamp_log2(avg_log2, MAX_AVG_LOG2)
                                : al_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_SAMPLE;
      ratio_q <= '0;
      al_q    <= '0;
    end else if (cfg_update) begin
      mode_q  <= mode_eff;
      ratio_q <= ratio_eff;
      al_q    <= al_eff;
    end
  end

  mso_decim_counter #(
    .CW (RATIO_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .advance  (advance),
    .mode     (mode_eff),
    .ratio    (ratio_eff),
    .avg_log2 (al_eff),
    .first    (first),
    .complete (complete),
    .busy     (busy)
  );

  assign din     = in_data;
  assign din_ext = {{MAX_AVG_LOG2{din[DW-1]}}, din};

  always_comb begin
    samp_d = samp_q;
    min_d  = min_q;
    max_d  = max_q;
    acc_d  = clear ? '0 : acc_q;
    if (advance) begin
      if (first) begin
        samp_d = din;
        min_d  = din;
        max_d  = din;
        acc_d  = din_ext;
      end else begin
        if (din < min_q) min_d = din;
        if (din > max_q) max_d = din;
        acc_d = acc_q + din_ext;
      end
    end
  end

  // Arithmetic shift floors toward -inf; the mean always fits DW.
  assign avg_res = DW'(acc_d >>> al_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
      min_q  <= '0;
      max_q  <= '0;
      acc_q  <= '0;
    end else begin
      samp_q <= samp_d;
      min_q  <= min_d;
      max_q  <= max_d;
      acc_q  <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_min   <= '0;
      out_max   <= '0;
    end else begin
      out_valid <= complete;
      if (complete) begin
        case (mode_eff)
          MODE_PEAK: begin
            out_data <= max_d;
            out_min  <= min_d;
            out_max  <= max_d;
          end
          MODE_AVG: begin
            out_data <= avg_res;
            out_min  <= avg_res;
            out_max  <= avg_res;
          end
          default: begin
            out_data <= samp_d;
            out_min  <= samp_d;
            out_max  <= samp_d;
          end
        endcase
      end
    end
  end

endmodule
